// File: rtl/shift_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : shift_seq_ctrl
// Purpose  : Command sequencer for the 8-bit rotating shift register: load,
//            rotate left/right N, no-op; reports sampled register value.
// Options  : SHIFT_SEQ_PERF_EN adds perf_clr input and busy_cycles counter.
// Revision : 1.0 - initial release
// ============================================================================
module shift_seq_ctrl #(
    parameter int CNT_W      = 3,
    parameter int SETTLE_CYC = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [CNT_W-1:0] cmd_cnt,
    input  logic [7:0]       cmd_data,
    output logic [1:0]       sr_select,
    output logic             sr_e,
    output logic [7:0]       sr_data,
    input  logic [7:0]       sr_q,
    output logic             done,
    output logic [7:0]       result
`ifdef SHIFT_SEQ_PERF_EN
    ,
    input  logic             perf_clr,
    output logic [15:0]      busy_cycles
`endif
);

    localparam logic [1:0] c_op_nop  = 2'b00;
    localparam logic [1:0] c_op_rol  = 2'b01;
    localparam logic [1:0] c_op_ror  = 2'b10;
    localparam logic [1:0] c_op_load = 2'b11;

    localparam logic [2:0]       c_settle_init = 3'(SETTLE_CYC - 1);
    localparam logic [CNT_W-1:0] c_cnt_one     = CNT_W'(1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_SHIFT  = 3'd2,
        ST_SETTLE = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [1:0]       r_op;
    logic [CNT_W-1:0] r_cnt;
    logic [7:0]       r_data;
    logic [2:0]       r_settle;
    logic [7:0]       r_result;
    logic             w_accept;

    assign w_accept  = cmd_valid && (r_state == ST_IDLE);
    assign cmd_ready = (r_state == ST_IDLE) && !rst;
    assign result    = r_result;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        sr_select = c_op_nop;
        sr_e      = 1'b0;
        sr_data   = 8'h00;
        done      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    if (cmd_op == c_op_load) begin
                        w_next = ST_LOAD;
                    end else if ((cmd_op == c_op_rol || cmd_op == c_op_ror) &&
                                 (cmd_cnt != '0)) begin
                        w_next = ST_SHIFT;
                    end else begin
                        w_next = ST_SETTLE;
                    end
                end
            end
            ST_LOAD: begin
                sr_select = c_op_load;
                sr_e      = 1'b1;
                sr_data   = r_data;
                w_next    = ST_SETTLE;
            end
            ST_SHIFT: begin
                sr_select = r_op;
                sr_e      = 1'b1;
                if (r_cnt == c_cnt_one) begin
                    w_next = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (r_settle == 3'd0) begin
                    w_next = ST_DONE;
                end
            end
            ST_DONE: begin
                done   = 1'b1;
                w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // Command latch, step/settle counters and the sampled result.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_op     <= c_op_nop;
            r_cnt    <= '0;
            r_data   <= 8'h00;
            r_settle <= 3'd0;
            r_result <= 8'h00;
        end else begin
            if (w_accept) begin
                r_op   <= cmd_op;
                r_cnt  <= cmd_cnt;
                r_data <= cmd_data;
            end else if (r_state == ST_SHIFT) begin
                r_cnt <= r_cnt - c_cnt_one;
            end

            if ((w_next == ST_SETTLE) && (r_state != ST_SETTLE)) begin
                r_settle <= c_settle_init;
            end else if ((r_state == ST_SETTLE) && (r_settle != 3'd0)) begin
                r_settle <= r_settle - 3'd1;
            end

            if ((r_state == ST_SETTLE) && (r_settle == 3'd0)) begin
                r_result <= sr_q;
            end
        end
    end

`ifdef SHIFT_SEQ_PERF_EN
    logic [15:0] r_busy_cycles;

    assign busy_cycles = r_busy_cycles;

    // Clear wins over counting; the count sticks at all-ones.
    always_ff @(posedge clk) begin
        if (rst || perf_clr) begin
            r_busy_cycles <= 16'h0000;
        end else if ((r_state != ST_IDLE) && (r_busy_cycles != 16'hFFFF)) begin
            r_busy_cycles <= r_busy_cycles + 16'h0001;
        end
    end
`else
`endif

endmodule
`default_nettype wire

// File: tb/tb_shift_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_shift_seq_ctrl
// Purpose  : Scoreboard bench for shift_seq_ctrl with a behavioural register.
// Revision : 1.0 - initial release
// ============================================================================
module tb_shift_seq_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [1:0] cmd_op = 2'b00;
    logic [2:0] cmd_cnt = 3'd0;
    logic [7:0] cmd_data = 8'h00;
    logic [1:0] sr_select;
    logic       sr_e;
    logic [7:0] sr_data;
    logic [7:0] sr_q = 8'h00;
    logic       done;
    logic [7:0] result;
`ifdef SHIFT_SEQ_PERF_EN
    logic        perf_clr = 1'b0;
    logic [15:0] busy_cycles;
`endif

    always #5 clk = ~clk;

    shift_seq_ctrl #(.CNT_W(3), .SETTLE_CYC(1)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_cnt   (cmd_cnt),
        .cmd_data  (cmd_data),
        .sr_select (sr_select),
        .sr_e      (sr_e),
        .sr_data   (sr_data),
        .sr_q      (sr_q),
        .done      (done),
        .result    (result)
`ifdef SHIFT_SEQ_PERF_EN
        ,
        .perf_clr    (perf_clr),
        .busy_cycles (busy_cycles)
`endif
    );

    // Rotating shift register the controller drives.
    always @(posedge clk) begin
        if (sr_e) begin
            case (sr_select)
                2'b01:   sr_q <= {sr_q[6:0], sr_q[7]};
                2'b10:   sr_q <= {sr_q[0], sr_q[7:1]};
                2'b11:   sr_q <= sr_data;
                default: sr_q <= sr_q;
            endcase
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, req, cyc);
    endtask

    typedef struct {
        logic [7:0] res;
        int         lat;
        int         en;
        logic [1:0] sel;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   t_acc     = 0;
    int   en_cnt    = 0;
    bit   sel_bad   = 1'b0;
    int   last_done = -100;
    int   n_done    = 0;

    // Monitor: tracks the active command and scores each done pulse.
    always @(negedge clk) begin
        if (rst) begin
            en_cnt  = 0;
            sel_bad = 1'b0;
        end else begin
            if (cmd_valid && cmd_ready) begin
                t_acc   = cyc;
                en_cnt  = 0;
                sel_bad = 1'b0;
            end
            if (sr_e) begin
                en_cnt++;
                if (sb.size() > 0 && sr_select != sb[0].sel) sel_bad = 1'b1;
            end else if (sr_select != 2'b00) begin
                sel_bad = 1'b1;
            end
            if (done) begin
                n_done++;
                last_done = cyc;
                if (sb.size() == 0) begin
                    n_total++;
                    $display("FAIL unexpected_done: got done=1 at cycle %0d, required no done", cyc);
                end else begin
                    e = sb.pop_front();
                    check("result", {24'h0, result}, {24'h0, e.res});
                    check("latency", cyc - t_acc, e.lat);
                    check("sr_e_cycles", en_cnt, e.en);
                    check("select_ok", {31'h0, sel_bad}, 32'h0);
                end
            end
        end
    end

    task automatic wait_hs(output int t);
        int k = 0;
        @(negedge clk);
        while (!cmd_ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        if (!cmd_ready) begin
            n_total++;
            $display("FAIL handshake_timeout: got cmd_ready=0 for 50 cycles, required 1");
        end
        t = cyc;
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [1:0] op, input logic [2:0] cnt, input logic [7:0] d,
                        input logic [7:0] res, input int lat, input int en);
        exp_t x;
        int   t;
        x.res = res;
        x.lat = lat;
        x.en  = en;
        x.sel = (en > 0) ? op : 2'b00;
        sb.push_back(x);
        cmd_op    = op;
        cmd_cnt   = cnt;
        cmd_data  = d;
        cmd_valid = 1'b1;
        wait_hs(t);
        cmd_valid = 1'b0;
    endtask

    task automatic drain();
        int k = 0;
        while (sb.size() != 0 && k < 100) begin
            @(posedge clk);
            k++;
        end
        if (sb.size() != 0) begin
            n_total++;
            $display("FAIL done_timeout: got %0d pending results, required 0", sb.size());
            sb.delete();
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        int t1;
        int t2;
        int nd;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_cmd_ready", {31'h0, cmd_ready}, 32'h0);
        check("rst_sr_e", {31'h0, sr_e}, 32'h0);
        check("rst_sr_select", {30'h0, sr_select}, 32'h0);
        check("rst_done", {31'h0, done}, 32'h0);
        check("rst_result", {24'h0, result}, 32'h0);
        @(posedge clk);
        #1 rst = 1'b0;

        send(2'b11, 3'd0, 8'hA5, 8'hA5, 3, 1);   // load
        drain();
        send(2'b01, 3'd3, 8'h00, 8'h2D, 5, 3);   // rotate left 3
        drain();
        send(2'b10, 3'd1, 8'h00, 8'h96, 3, 1);   // rotate right 1
        drain();
        send(2'b01, 3'd0, 8'hFF, 8'h96, 2, 0);   // zero-count rotate
        drain();
        send(2'b00, 3'd5, 8'h00, 8'h96, 2, 0);   // no-op ignores count
        drain();
        send(2'b01, 3'd7, 8'h00, 8'h4B, 9, 7);   // maximum count
        drain();

        // Reset in the middle of a rotate right 7.
        cmd_op    = 2'b10;
        cmd_cnt   = 3'd7;
        cmd_valid = 1'b1;
        wait_hs(t1);
        cmd_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        check("sr_e_before_rst", {31'h0, sr_e}, 32'h1);
        nd = n_done;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("midrst_sr_e", {31'h0, sr_e}, 32'h0);
        check("midrst_result", {24'h0, result}, 32'h0);
        check("midrst_cmd_ready", {31'h0, cmd_ready}, 32'h1);
        repeat (12) @(posedge clk);
        check("midrst_no_done", n_done, nd);
`ifdef SHIFT_SEQ_PERF_EN
        check("busy_after_rst", {16'h0, busy_cycles}, 32'h0);
`endif

        // Back-to-back with cmd_valid held high.
        #1;
        begin
            exp_t x;
            x.res = 8'h3C; x.lat = 3; x.en = 1; x.sel = 2'b11;
            sb.push_back(x);
            x.res = 8'hE1; x.lat = 5; x.en = 3; x.sel = 2'b01;
            sb.push_back(x);
        end
        cmd_op    = 2'b11;
        cmd_data  = 8'h3C;
        cmd_valid = 1'b1;
        wait_hs(t1);
        cmd_op  = 2'b01;
        cmd_cnt = 3'd3;
        wait_hs(t2);
        cmd_valid = 1'b0;
        check("b2b_accept_cycle", t2, last_done + 1);
        drain();
`ifdef SHIFT_SEQ_PERF_EN
        check("busy_cycles", {16'h0, busy_cycles}, 32'd8);
        perf_clr = 1'b1;
        @(posedge clk);
        #1 perf_clr = 1'b0;
        @(negedge clk);
        check("busy_after_clr", {16'h0, busy_cycles}, 32'h0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/shift_seq_ctrl.md
Name: shift_seq_ctrl

Overview:
Command sequencer for the 8-bit rotating shift register datapath. It accepts one command at a time over a valid/ready handshake: parallel load, rotate left N, rotate right N, or no-op. It drives the register's select, enable and parallel-data inputs for the required number of cycles, then samples the register output and reports it with a one-cycle done pulse.

Parameters:
CNT_W, 3, width of the shift-count field; rotate counts run 0..2^CNT_W-1.
SETTLE_CYC, 1, idle cycles (sr_e=0) after the last enable before sr_q is sampled; legal range 1..4.

Ports:
clk  in  1  rising-edge clock, shared with the shift register
rst  in  1  reset; synchronous, active-high
cmd_valid  in  1  command present
cmd_ready  out  1  controller can accept a command
cmd_op  in  2  00 no-op, 01 rotate left (toward MSB), 10 rotate right (toward LSB), 11 parallel load
cmd_cnt  in  CNT_W  number of rotate steps; ignored for load and no-op
cmd_data  in  8  parallel load value
sr_select  out  2  to register select, same encoding as cmd_op
sr_e  out  1  to register enable
sr_data  out  8  to register parallel data
sr_q  in  8  register output
done  out  1  one-cycle completion pulse
result  out  8  sr_q sampled at completion; held until the next done

Behaviour:
- Reset: state IDLE; cmd_ready=0 during the reset cycle; sr_select=00, sr_e=0, sr_data=0, done=0, result=0, internal counters=0.
- States: IDLE, LOAD, SHIFT, SETTLE, DONE.
- IDLE: cmd_ready=1; accept on cmd_valid&&cmd_ready at edge T. Latch op, cnt and data.
- Transitions out of IDLE:
  - load goes to LOAD.
  - rotate with cnt>0 goes to SHIFT.
  - rotate with cnt==0, or no-op, goes straight to SETTLE.
- cmd_ready=0 in every state except IDLE. cmd_* is ignored while busy.
- LOAD: exactly one cycle (T+1), with sr_select=11, sr_e=1, sr_data=latched data. Next state SETTLE.
- SHIFT: cycles T+1..T+N, with sr_select=op, sr_e=1, sr_data=0. The step counter decrements each cycle; on reaching 1 the next state is SETTLE.
- SETTLE: SETTLE_CYC cycles with sr_select=00, sr_e=0. At the end, result<=sr_q and go to DONE.
- DONE: done=1 for exactly one cycle, then IDLE. cmd_ready is 0 in DONE, so a new command is accepted at the earliest in the cycle after done.
- Latency with SETTLE_CYC=1, where done is asserted in the cycle after edge T+k:
  - load: done at T+3.
  - rotate N>0: done at T+N+2.
  - zero-count or no-op: done at T+2.
- sr_e is never high outside LOAD and SHIFT. sr_select is 00 whenever sr_e=0.
- Count arithmetic: unsigned CNT_W bits, no wrap. Maximum N = 2^CNT_W-1. A count of 8 is not expressible at the default width and is equivalent to 0.
- Reset mid-operation: immediate return to IDLE, no done, sr_e=0 on the next cycle, result cleared to 0.
- cmd_valid held high across done: the next command is accepted in the first IDLE cycle. Back-to-back throughput is one command per (latency+1) cycles.

Optional Feature:
Macro SHIFT_SEQ_PERF_EN.
- Defined: adds output port busy_cycles (16 bits).
  - Increments by 1 on every cycle the state is not IDLE.
  - Saturates at 0xFFFF.
  - Cleared by rst and by a one-cycle input perf_clr (1 bit), which has priority over the increment.
- Undefined: neither port exists and there is no counter logic.
- Core timing is identical with or without the macro.

Test Plan:
1. Load: reset, then load 0xA5 accepted at T. Expect sr_e=1 and sr_select=11 only at T+1, done at T+3, result=0xA5.
2. Rotate left 3 after loading 0xA5. Expect sr_e high for exactly 3 cycles with sr_select=01, done at T+5, result=0x2D.
3. Rotate right 1 after state 0x2D. Expect result=0x96, done at T+3.
4. Zero count: rotate left with cnt=0, then no-op with state 0x96. For each, expect sr_e never asserted, done at T+2, result=0x96.
5. Reset mid-operation: rotate right 7, assert rst at T+3. Expect no done, result=0, sr_e=0 from T+4, cmd_ready=1 after rst is released.
6. Back-to-back and perf: cmd_valid held high with two commands; expect the second accepted the cycle after the first done. With SHIFT_SEQ_PERF_EN defined, busy_cycles equals the sum of busy cycles (load 3 + rotate-left-3 5 = 8); perf_clr returns it to 0.
